ps2_keyboard_receiver: RTL

- Keyboard input peripheral: deserialises PS/2 device-to-host frames, buffers received scan-code bytes in a small FIFO, and hands them to the processor.
- Processor handshake uses a level FLAG plus a `done` return. It mirrors the LCD char/FLAG_lcd/done path in the opposite direction, so the clock controller stalls the CPU until a byte is delivered.
- Runs on clk_50 beside the IO, Debouncer and LCD blocks. Its output feeds MUX_Data_Write as keyboard data.

---
 rtl/ps2_keyboard_receiver_pkg.sv | 16 +
 rtl/keyboard_fifo.sv | 59 +++++
 rtl/ps2_keyboard_receiver.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_receiver_pkg.sv
// Shared types and frame constants for the PS/2 keyboard receiver.
package ps2_keyboard_receiver_pkg;

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DONE} rd_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_BITS = 8;

   // Odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic p);
      return (^data) ^ p;
   endfunction

endpackage

// File: rtl/keyboard_fifo.sv
// Small synchronous FIFO for received scan-code bytes; registered empty flag.
module keyboard_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  empty,
   output logic                  full
);
   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count, w_count_nxt;
   logic                  r_empty, w_do_push, w_do_pop;

   // A full FIFO still accepts a push when a pop frees a slot in the same clk.
   assign w_do_pop  = pop && !r_empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign full      = (r_count == (ADDR_WIDTH+1)'(DEPTH));
   assign dout      = r_mem[r_rd_ptr];
   assign empty     = r_empty;

   // Occupancy after this clk's accepted push/pop
   always_comb begin
      w_count_nxt = r_count;
      if (w_do_push && !w_do_pop)
         w_count_nxt = r_count + 1'b1;
      else if (w_do_pop && !w_do_push)
         w_count_nxt = r_count - 1'b1;
   end

   // Storage array, written on accepted push
   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= din;
   end

   // Pointers, count and registered empty flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
      end
   end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 device-to-host frame receiver with byte FIFO and FLAG/done read handshake.
module ps2_keyboard_receiver
   import ps2_keyboard_receiver_pkg::*;
#(
   parameter int FIFO_ADDR_WIDTH = 3,
   parameter int FILTER_LEN      = 8,
   parameter int TIMEOUT_WIDTH   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       FLAG_keyboard,
   output logic [7:0] char,
   output logic       done,
   output logic       empty,
   output logic       overflow,
   output logic       parity_error
);
   localparam int FILT_W = $clog2(FILTER_LEN + 1);

   logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_clk_f;
   logic [FILT_W-1:0] r_filt_cnt;
   logic w_strobe;

   rx_state_t r_rx_state, w_rx_next;
   logic [2:0] r_bitcnt;
   logic [7:0] r_shift;
   logic r_par_ok;
   logic [TIMEOUT_WIDTH-1:0] r_tmo;
   logic w_tmo_hit, w_frame_end, w_push, w_frame_err;

   rd_state_t r_rd_state, w_rd_next;
   logic r_flag, r_flag_d, w_flag_rise, w_pop;
   logic [7:0] r_char, w_dout;
   logic w_full, w_fifo_empty, r_overflow, r_parity_error;

   // Two-flop synchronisers on both PS/2 lines
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_data;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // Filtered clock flips after FILTER_LEN consecutive samples disagree with it
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_clk_f    <= 1'b1;
         r_filt_cnt <= '0;
      end else if (r_clk_s2 == r_clk_f) begin
         r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
         r_clk_f    <= r_clk_s2;
         r_filt_cnt <= '0;
      end else begin
         r_filt_cnt <= r_filt_cnt + 1'b1;
      end
   end

   // Bit strobe: the clk on which the filtered clock falls; data sampled now
   assign w_strobe  = r_clk_f && !r_clk_s2 && (r_filt_cnt == FILT_W'(FILTER_LEN - 1));
   assign w_tmo_hit = (r_rx_state != RX_IDLE) && (&r_tmo);

   // Frame FSM state register
   always_ff @(posedge clk) begin
      if (!reset) r_rx_state <= RX_IDLE;
      else        r_rx_state <= w_rx_next;
   end

   // Frame FSM next state; a stalled frame falls back to idle silently
   always_comb begin
      w_rx_next = r_rx_state;
      if (w_tmo_hit)
         w_rx_next = RX_IDLE;
      else if (w_strobe) begin
         case (r_rx_state)
            RX_IDLE:   if (r_dat_s2 == START_BIT) w_rx_next = RX_DATA;
            RX_DATA:   if (r_bitcnt == 3'(DATA_BITS - 1)) w_rx_next = RX_PARITY;
            RX_PARITY: w_rx_next = RX_STOP;
            default:   w_rx_next = RX_IDLE;
         endcase
      end
   end

   // Frame FSM outputs: push a good byte or flag a bad frame at the stop bit
   always_comb begin
      w_frame_end = !w_tmo_hit && w_strobe && (r_rx_state == RX_STOP);
      w_push      = w_frame_end && (r_dat_s2 == STOP_BIT) && r_par_ok;
      w_frame_err = w_frame_end && !w_push;
   end

   // Frame datapath: shift register, bit counter, parity result, timeout counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_par_ok <= 1'b0;
         r_tmo    <= '0;
      end else begin
         if (r_rx_state == RX_IDLE || w_strobe) r_tmo <= '0;
         else                                   r_tmo <= r_tmo + 1'b1;
         if (w_strobe && !w_tmo_hit) begin
            case (r_rx_state)
               RX_IDLE:   r_bitcnt <= '0;
               RX_DATA: begin
                  r_shift  <= {r_dat_s2, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 1'b1;
               end
               RX_PARITY: r_par_ok <= odd_parity_ok(r_shift, r_dat_s2);
               default:   ;
            endcase
         end
      end
   end

   keyboard_fifo #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .din   (r_shift),
      .dout  (w_dout),
      .empty (w_fifo_empty),
      .full  (w_full)
   );

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_overflow     <= 1'b0;
         r_parity_error <= 1'b0;
      end else begin
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
         if (w_frame_err)                r_parity_error <= 1'b1;
      end
   end

   // Register the request once and keep a delayed copy for edge detection
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_flag   <= 1'b0;
         r_flag_d <= 1'b0;
      end else begin
         r_flag   <= FLAG_keyboard;
         r_flag_d <= r_flag;
      end
   end

   assign w_flag_rise = r_flag && !r_flag_d;

   // Read FSM state register
   always_ff @(posedge clk) begin
      if (!reset) r_rd_state <= RD_IDLE;
      else        r_rd_state <= w_rd_next;
   end

   // Read FSM next state; one delivery per FLAG high period
   always_comb begin
      w_rd_next = r_rd_state;
      case (r_rd_state)
         RD_IDLE: if (w_flag_rise) w_rd_next = w_fifo_empty ? RD_WAIT : RD_DONE;
         RD_WAIT: begin
            if (!FLAG_keyboard)     w_rd_next = RD_IDLE;
            else if (!w_fifo_empty) w_rd_next = RD_DONE;
         end
         RD_DONE: if (!FLAG_keyboard) w_rd_next = RD_IDLE;
         default: w_rd_next = RD_IDLE;
      endcase
   end

   // Read FSM outputs: pop exactly when moving into RD_DONE
   always_comb begin
      w_pop = 1'b0;
      case (r_rd_state)
         RD_IDLE: w_pop = w_flag_rise && !w_fifo_empty;
         RD_WAIT: w_pop = FLAG_keyboard && !w_fifo_empty;
         default: w_pop = 1'b0;
      endcase
   end

   // Delivered byte, held after the handshake completes
   always_ff @(posedge clk) begin
      if (!reset)     r_char <= '0;
      else if (w_pop) r_char <= w_dout;
   end

   assign char         = r_char;
   assign done         = (r_rd_state == RD_DONE);
   assign empty        = w_fifo_empty;
   assign overflow     = r_overflow;
   assign parity_error = r_parity_error;

endmodule
